// File: rtl/drive_pkg.sv
// drive_pkg: shared types and constants for the line-following drive controller.
//   - FSM state encoding (3 bits, exported on the top-level state port)
//   - H-bridge direction codes and the side used to remember the last turn
//   - duty width / saturation limit and an elaboration-time duty clamp
package drive_pkg;

  localparam int DUTY_W   = 10;
  localparam int DUTY_MAX = (1 << DUTY_W) - 1;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FORWARD = 3'd1,
    ST_TURN_L  = 3'd2,
    ST_TURN_R  = 3'd3,
    ST_SEARCH  = 3'd4,
    ST_STOP    = 3'd5
  } state_e;

  typedef enum logic {
    SIDE_LEFT  = 1'b0,
    SIDE_RIGHT = 1'b1
  } side_e;

  localparam logic [1:0] DIR_OFF = 2'b00;
  localparam logic [1:0] DIR_REV = 2'b01;
  localparam logic [1:0] DIR_FWD = 2'b10;

  // Duty parameters are integers; anything outside 0..DUTY_MAX is pinned to the range.
  function automatic duty_t clamp_duty(input int v);
    if (v > DUTY_MAX) return duty_t'(DUTY_MAX);
    else if (v < 0)   return '0;
    else              return duty_t'(v);
  endfunction

endpackage

// File: rtl/motor_ramp.sv
// motor_ramp: per-motor soft ramp with zero-crossing direction reversal.
//   clk, rst      : clock, synchronous active-high reset
//   tick          : control tick; duty/direction only move on ticks
//   tgt_duty      : requested duty (0..1023)
//   tgt_dir       : requested H-bridge code (10 fwd, 01 rev, 00 off)
//   duty, dir, en : applied duty, applied H-bridge code, PWM enable (duty != 0)
// A direction change first ramps duty to zero, flips the code on the tick after
// zero is reached, and only then ramps toward the new target.
module motor_ramp
  import drive_pkg::*;
#(
  parameter int RAMP_STEP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic [1:0]        tgt_dir,
  output logic [DUTY_W-1:0] duty,
  output logic [1:0]        dir,
  output logic              en
);

  localparam logic [DUTY_W:0] STEP = {1'b0, clamp_duty(RAMP_STEP)};

  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [1:0]        dir_q, dir_d;
  logic [DUTY_W:0]   cur, tgt, nxt;

  always_comb begin
    cur   = {1'b0, duty_q};
    tgt   = {1'b0, tgt_duty};
    nxt   = cur;
    dir_d = dir_q;
    if (tick) begin
      if (tgt_dir == dir_q) begin
        // Same direction: step toward target, landing exactly on it.
        if (tgt > cur) nxt = ((tgt - cur) > STEP) ? cur + STEP : tgt;
        else           nxt = ((cur - tgt) > STEP) ? cur - STEP : tgt;
      end else if (duty_q != '0) begin
        // Direction change pending: head for zero regardless of target.
        nxt = (cur > STEP) ? cur - STEP : '0;
      end else begin
        // Sitting at zero: flip the bridge now, ramp-up starts next tick.
        dir_d = tgt_dir;
      end
    end
    duty_d = nxt[DUTY_W] ? '1 : nxt[DUTY_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      dir_q  <= DIR_OFF;
    end else begin
      duty_q <= duty_d;
      dir_q  <= dir_d;
    end
  end

  assign duty = duty_q;
  assign dir  = dir_q;
  assign en   = (duty_q != '0);

endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer: closed-loop drive controller for the line-following car.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : one-cycle pulse; leaves IDLE, or STOP -> IDLE
//   obstacle              : level; forces STOP from any non-IDLE state
//   sensor[2:0]           : {left, mid, right} IR sensors, 1 = on line, async
//   left/right_duty       : PWM duty per motor (0..1023)
//   left/right_en         : PWM enable per motor
//   l_IN, r_IN            : H-bridge codes (10 fwd, 01 rev, 00 off)
//   state                 : current FSM state
//   fault                 : sticky search-timeout flag, cleared on STOP exit
// Contains the tick divider, sensor synchroniser/debouncer and drive FSM;
// the two motor_ramp instances turn FSM targets into smooth motor commands.
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int DEB_TICKS    = 3,
  parameter int RAMP_STEP    = 16,
  parameter int FWD_DUTY     = 700,
  parameter int TURN_FAST    = 800,
  parameter int TURN_SLOW    = 300,
  parameter int SEARCH_DUTY  = 600,
  parameter int SEARCH_TICKS = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              obstacle,
  input  logic [2:0]        sensor,
  output logic [DUTY_W-1:0] left_duty,
  output logic [DUTY_W-1:0] right_duty,
  output logic              left_en,
  output logic              right_en,
  output logic [1:0]        l_IN,
  output logic [1:0]        r_IN,
  output logic [2:0]        state,
  output logic              fault
);

  localparam int    DIV    = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
  localparam int    CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int    DEB_N  = (DEB_TICKS > 0) ? DEB_TICKS : 1;
  localparam int    DW     = $clog2(DEB_N + 1);
  localparam int    TO_N   = (SEARCH_TICKS > 0) ? SEARCH_TICKS : 1;
  localparam int    TW     = $clog2(TO_N + 1);
  localparam duty_t FWD_C  = clamp_duty(FWD_DUTY);
  localparam duty_t FAST_C = clamp_duty(TURN_FAST);
  localparam duty_t SLOW_C = clamp_duty(TURN_SLOW);
  localparam duty_t SRCH_C = clamp_duty(SEARCH_DUTY);

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    cand_q, cand_d, pat_q, pat_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          pat_upd_q, pat_upd_d;
  state_e        state_q, state_d;
  side_e         last_turn_q, last_turn_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          fault_q, fault_d;
  logic          eval;
  duty_t         l_tgt, r_tgt;
  logic [1:0]    l_tdir, r_tdir;

  // Free-running tick divider.
  assign tick = (tick_cnt_q == CW'(DIV - 1));
  always_comb tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);

  // Debounce on ticks: a new sample restarts the run, DEB_N equal samples accept it.
  always_comb begin
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    pat_d     = pat_q;
    pat_upd_d = 1'b0;
    if (tick) begin
      if (s2_q != cand_q) begin
        cand_d    = s2_q;
        deb_cnt_d = DW'(1);
      end else if (deb_cnt_q != DW'(DEB_N)) begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
      if (deb_cnt_d == DW'(DEB_N) && cand_d != pat_q) begin
        pat_d     = cand_d;
        pat_upd_d = 1'b1;
      end
    end
  end

  // Running states react to a freshly accepted pattern or to any tick.
  assign eval = tick | pat_upd_q;

  always_comb begin
    state_d     = state_q;
    last_turn_d = last_turn_q;
    to_cnt_d    = to_cnt_q;
    fault_d     = fault_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FORWARD;
      ST_STOP: begin
        if (start && !obstacle) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end
      default: begin
        if (eval) begin
          case (pat_q)
            3'b010, 3'b111: state_d = ST_FORWARD;
            3'b100, 3'b110: begin
              state_d     = ST_TURN_L;
              last_turn_d = SIDE_LEFT;
            end
            3'b001, 3'b011: begin
              state_d     = ST_TURN_R;
              last_turn_d = SIDE_RIGHT;
            end
            3'b000:  state_d = ST_SEARCH;
            default: ;  // 101 straddles the line: keep going as before
          endcase
        end
        if (state_q != ST_SEARCH && state_d == ST_SEARCH) begin
          to_cnt_d = '0;
        end else if (state_q == ST_SEARCH && state_d == ST_SEARCH && tick) begin
          if (to_cnt_q == TW'(TO_N - 1)) begin
            state_d = ST_STOP;
            fault_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
      end
    endcase
    if (obstacle && state_q != ST_IDLE) state_d = ST_STOP;
  end

  // Motor targets from the current state; SEARCH spins toward the last turn side.
  always_comb begin
    l_tgt  = '0;
    r_tgt  = '0;
    l_tdir = DIR_OFF;
    r_tdir = DIR_OFF;
    case (state_q)
      ST_FORWARD: begin
        l_tgt = FWD_C;  r_tgt = FWD_C;  l_tdir = DIR_FWD; r_tdir = DIR_FWD;
      end
      ST_TURN_L: begin
        l_tgt = SLOW_C; r_tgt = FAST_C; l_tdir = DIR_FWD; r_tdir = DIR_FWD;
      end
      ST_TURN_R: begin
        l_tgt = FAST_C; r_tgt = SLOW_C; l_tdir = DIR_FWD; r_tdir = DIR_FWD;
      end
      ST_SEARCH: begin
        l_tgt  = SRCH_C;
        r_tgt  = SRCH_C;
        l_tdir = (last_turn_q == SIDE_LEFT)  ? DIR_REV : DIR_FWD;
        r_tdir = (last_turn_q == SIDE_RIGHT) ? DIR_REV : DIR_FWD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      cand_q      <= '0;
      pat_q       <= '0;
      deb_cnt_q   <= '0;
      pat_upd_q   <= 1'b0;
      state_q     <= ST_IDLE;
      last_turn_q <= SIDE_LEFT;
      to_cnt_q    <= '0;
      fault_q     <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      s1_q        <= sensor;
      s2_q        <= s1_q;
      cand_q      <= cand_d;
      pat_q       <= pat_d;
      deb_cnt_q   <= deb_cnt_d;
      pat_upd_q   <= pat_upd_d;
      state_q     <= state_d;
      last_turn_q <= last_turn_d;
      to_cnt_q    <= to_cnt_d;
      fault_q     <= fault_d;
    end
  end

  motor_ramp #(.RAMP_STEP(RAMP_STEP)) u_left (
    .clk(clk), .rst(rst), .tick(tick),
    .tgt_duty(l_tgt), .tgt_dir(l_tdir),
    .duty(left_duty), .dir(l_IN), .en(left_en)
  );

  motor_ramp #(.RAMP_STEP(RAMP_STEP)) u_right (
    .clk(clk), .rst(rst), .tick(tick),
    .tgt_duty(r_tgt), .tgt_dir(r_tdir),
    .duty(right_duty), .dir(r_IN), .en(right_en)
  );

  assign state = state_q;
  assign fault = fault_q;

endmodule
